// File: rtl/cbd_stream.sv
// Centered binomial sampler: byte stream in, 12-bit coefficient beats out.
// Ports: i_clk/i_rstn, i_start/i_eta/i_mode, i_ibytes stream, o_coeffs stream, o_busy/o_done/o_err.
module cbd_stream #(
  parameter int P_IW = 64,
  parameter int P_NC = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic [1:0]           i_eta,
  input  logic                 i_mode,
  input  logic [P_IW-1:0]      i_ibytes,
  input  logic                 i_ibytes_valid,
  output logic                 o_ibytes_ready,
  output logic [12*P_NC-1:0]   o_coeffs,
  output logic                 o_coeffs_valid,
  input  logic                 i_coeffs_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int CAP = P_IW + 6*P_NC;
  localparam int OW  = 12*P_NC;
  localparam int FW  = $clog2(CAP+1);
  localparam int NB  = 256/P_NC;
  localparam int W2  = 1024/P_IW;
  localparam int W3  = 1536/P_IW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nstate;

  logic          eta3;
  logic          mode;
  logic [CAP-1:0] bits;
  logic [FW-1:0]  fill;
  logic [8:0]     words_left;
  logic [8:0]     beats_left;
  logic [OW-1:0]  out_q;
  logic           out_vld;
  logic           err_q;

  logic          run;
  logic          start_ok;
  logic          pop;
  logic          form;
  logic          push;
  logic          room;
  logic [FW-1:0] need;
  logic [FW-1:0] fill_eff;
  logic [FW-1:0] fill_n;
  logic [CAP-1:0] shifted;
  logic [CAP-1:0] word_ext;
  logic [CAP-1:0] bits_n;
  logic [P_IW-1:0] word_lsb;
  logic [OW-1:0]  beat_c;

  assign run      = (state == RUN);
  assign start_ok = (state == IDLE) & i_start & i_eta[1];
  assign need     = eta3 ? FW'(6*P_NC) : FW'(4*P_NC);
  assign pop      = out_vld & i_coeffs_ready;
  assign form     = run & (fill >= need) & (~out_vld | pop);
  assign fill_eff = form ? (fill - need) : fill;

  // Room is judged after this cycle's beat is removed, so a full
  // buffer can still take a word while a beat drains.
  assign room = ({1'b0, fill_eff} + (FW+1)'(P_IW)) <= (FW+1)'(CAP);
  assign o_ibytes_ready = run & (words_left != 9'd0) & room;
  assign push = o_ibytes_ready & i_ibytes_valid;

  // First byte sits in the MSBs; lay bytes out so stream bit k is bit k.
  always_comb begin
    word_lsb = '0;
    for (int b = 0; b < P_IW/8; b++) begin
      word_lsb[8*b +: 8] = i_ibytes[P_IW-8-8*b +: 8];
    end
  end

  always_comb begin
    word_ext = {{(CAP-P_IW){1'b0}}, word_lsb};
    shifted  = form ? (bits >> need) : bits;
    bits_n   = shifted;
    fill_n   = fill_eff;
    if (push) begin
      bits_n = shifted | (word_ext << fill_eff);
      fill_n = fill_eff + FW'(P_IW);
    end
  end

  always_comb begin
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [2:0]  d;
    logic [11:0] d12;
    beat_c = '0;
    sa  = '0;
    sb  = '0;
    d   = '0;
    d12 = '0;
    for (int i = 0; i < P_NC; i++) begin
      if (eta3) begin
        sa = {2'b0, bits[6*i]}   + {2'b0, bits[6*i+1]}
           + {2'b0, bits[6*i+2]};
        sb = {2'b0, bits[6*i+3]} + {2'b0, bits[6*i+4]}
           + {2'b0, bits[6*i+5]};
      end else begin
        sa = {2'b0, bits[4*i]}   + {2'b0, bits[4*i+1]};
        sb = {2'b0, bits[4*i+2]} + {2'b0, bits[4*i+3]};
      end
      d   = sa - sb;
      d12 = {{9{d[2]}}, d};
      if (mode && d[2]) begin
        d12 = d12 + 12'd3329;
      end
      beat_c[12*i +: 12] = d12;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    o_done = 1'b0;
    o_busy = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) nstate = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (pop && beats_left == 9'd1) nstate = DONE;
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      eta3       <= 1'b0;
      mode       <= 1'b0;
      bits       <= '0;
      fill       <= '0;
      words_left <= '0;
      beats_left <= '0;
      out_q      <= '0;
      out_vld    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state == IDLE) & i_start & ~i_eta[1];
      if (start_ok) begin
        eta3       <= i_eta[0];
        mode       <= i_mode;
        bits       <= '0;
        fill       <= '0;
        words_left <= i_eta[0] ? 9'(W3) : 9'(W2);
        beats_left <= 9'(NB);
        out_vld    <= 1'b0;
      end else if (run) begin
        bits <= bits_n;
        fill <= fill_n;
        if (push) words_left <= words_left - 9'd1;
        if (pop)  beats_left <= beats_left - 9'd1;
        if (form) begin
          out_q   <= beat_c;
          out_vld <= 1'b1;
        end else if (pop) begin
          out_vld <= 1'b0;
        end
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

  assign o_coeffs       = out_q;
  assign o_coeffs_valid = out_vld;
  assign o_err          = err_q;

endmodule

// File: tb/tb_cbd_stream.sv
// Directed bench for cbd_stream: pattern table, golden model with
// backpressure, error starts, restart-while-busy and mid-run reset.
module tb_cbd_stream;
  localparam int IW = 64;
  localparam int NC = 8;
  localparam int OW = 12*NC;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    eta = 2'd0;
  logic          mode = 1'b0;
  logic [IW-1:0] ibytes = '0;
  logic          ivalid = 1'b0;
  logic          iready;
  logic [OW-1:0] coeffs;
  logic          cvalid;
  logic          cready = 1'b1;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  cbd_stream #(.P_IW(IW), .P_NC(NC)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_start(start),
    .i_eta(eta),
    .i_mode(mode),
    .i_ibytes(ibytes),
    .i_ibytes_valid(ivalid),
    .o_ibytes_ready(iready),
    .o_coeffs(coeffs),
    .o_coeffs_valid(cvalid),
    .i_coeffs_ready(cready),
    .o_busy(busy),
    .o_done(done),
    .o_err(err)
  );

  typedef struct {
    int          eta;
    bit          mode;
    logic [7:0]  b;
    logic [47:0] e;
    int          rs;
  } vec_t;

  vec_t          vt [11];
  int            total = 0;
  int            passed = 0;
  logic [7:0]    stim [0:191];
  logic [OW-1:0] got [$];
  int            words_in;
  int            done_cnt;
  int            lat;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive_word();
    int idx;
    for (int b = 0; b < IW/8; b++) begin
      idx = 8*words_in + b;
      ibytes[IW-1-8*b -: 8] = (idx < 192) ? stim[idx] : 8'hA5;
    end
  endtask

  function automatic logic bitk(input int k);
    logic [7:0] by;
    by = stim[k/8];
    return by[k%8];
  endfunction

  function automatic logic [11:0] model(input int i, input int e,
                                        input bit m);
    int a = 0;
    int b = 0;
    int d;
    for (int j = 0; j < e; j++) begin
      a += int'(bitk(2*e*i + j));
      b += int'(bitk(2*e*i + e + j));
    end
    d = a - b;
    if (d < 0) d = m ? d + 3329 : d + 4096;
    return 12'(d);
  endfunction

  task automatic run_poly(input int e, input bit m, input bit bp,
                          input int rs, output int lat_o);
    int n;
    int after;
    bit seen;
    bit stall;
    logic [OW-1:0] held;
    got.delete();
    words_in = 0;
    done_cnt = 0;
    lat_o = -1;
    seen = 0;
    stall = 0;
    after = 0;
    held = '0;
    @(posedge clk); #1;
    start = 1'b1;
    eta = 2'(e);
    mode = m;
    ivalid = 1'b1;
    cready = ~bp;
    drive_word();
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 400 && after < 3) begin
      @(negedge clk);
      if (stall) check("stall_hold", {cvalid, coeffs}, {1'b1, held});
      stall = cvalid & ~cready;
      held = coeffs;
      if (bp && n == 10) begin
        check("bp_ready_low", iready, 0);
        check("bp_words", words_in, 2);
        check("bp_valid", cvalid, 1);
      end
      if (cvalid && cready) got.push_back(coeffs);
      if (iready && ivalid) words_in++;
      if (done) begin
        done_cnt++;
        if (!seen) lat_o = n;
        seen = 1;
      end
      if (seen) after++;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == rs) begin
        start = 1'b1;
        eta = 2'd3;
        mode = ~m;
      end
      drive_word();
      if (bp) cready = (n <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    ivalid = 1'b0;
    cready = 1'b1;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic check_poly(input int e, input bit m, input bit gold,
                            input logic [47:0] pat, input bit chk_lat);
    logic [OW-1:0] want;
    int nb;
    check("beats", got.size(), 32);
    check("words", words_in, (e == 3) ? 24 : 16);
    check("done_cnt", done_cnt, 1);
    if (chk_lat) check("latency", (lat >= 0 && lat <= 36), 1);
    nb = (got.size() < 32) ? got.size() : 32;
    for (int bt = 0; bt < nb; bt++) begin
      for (int k = 0; k < NC; k++) begin
        if (gold) want[12*k +: 12] = model(bt*NC + k, e, m);
        else      want[12*k +: 12] = pat[12*(k%4) +: 12];
      end
      check($sformatf("beat%0d", bt), got[bt], want);
    end
  endtask

  initial begin
    vt[0]  = '{2, 0, 8'h00, {12'h000, 12'h000, 12'h000, 12'h000}, -1};
    vt[1]  = '{2, 0, 8'h0C, {12'h000, 12'hFFE, 12'h000, 12'hFFE}, 5};
    vt[2]  = '{2, 1, 8'h0C, {12'h000, 12'hCFF, 12'h000, 12'hCFF}, -1};
    vt[3]  = '{2, 0, 8'h03, {12'h000, 12'h002, 12'h000, 12'h002}, -1};
    vt[4]  = '{2, 0, 8'hC3, {12'hFFE, 12'h002, 12'hFFE, 12'h002}, -1};
    vt[5]  = '{2, 1, 8'hC3, {12'hCFF, 12'h002, 12'hCFF, 12'h002}, -1};
    vt[6]  = '{2, 0, 8'h41, {12'hFFF, 12'h001, 12'hFFF, 12'h001}, -1};
    vt[7]  = '{2, 1, 8'h41, {12'hD00, 12'h001, 12'hD00, 12'h001}, -1};
    vt[8]  = '{3, 0, 8'hFF, {12'h000, 12'h000, 12'h000, 12'h000}, -1};
    vt[9]  = '{3, 0, 8'h07, {12'h001, 12'hFFE, 12'hFFF, 12'h003}, -1};
    vt[10] = '{3, 1, 8'h07, {12'h001, 12'hCFF, 12'hD00, 12'h003}, -1};

    @(negedge clk);
    check("reset_outs", {coeffs, cvalid, iready, busy, done, err}, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      start = 1'b1;
      eta = (v == 0) ? 2'd1 : 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("err_pulse", {err, busy}, 2'b10);
      @(negedge clk);
      check("err_clear", {err, busy}, 2'b00);
    end

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 192; i++) stim[i] = vt[v].b;
      run_poly(vt[v].eta, vt[v].mode, 1'b0, vt[v].rs, lat);
      check_poly(vt[v].eta, vt[v].mode, 1'b0, vt[v].e, 1'b1);
    end

    for (int i = 0; i < 192; i++) stim[i] = 8'($urandom);
    run_poly(3, 1'b0, 1'b1, -1, lat);
    check_poly(3, 1'b0, 1'b1, 48'h0, 1'b0);

    for (int i = 0; i < 192; i++) stim[i] = 8'($urandom);
    run_poly(2, 1'b1, 1'b0, -1, lat);
    check_poly(2, 1'b1, 1'b1, 48'h0, 1'b1);

    for (int i = 0; i < 192; i++) stim[i] = 8'h11;
    words_in = 0;
    @(posedge clk); #1;
    start = 1'b1;
    eta = 2'd2;
    mode = 1'b0;
    ivalid = 1'b1;
    drive_word();
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && words_in < 5; k++) begin
      @(negedge clk);
      if (iready && ivalid) words_in++;
      @(posedge clk); #1;
      drive_word();
    end
    check("busy_pre_rst", {busy, cvalid}, 2'b11);
    rstn = 1'b0;
    #1;
    check("rst_async", {coeffs, cvalid, iready, busy, done, err}, 0);
    ivalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 192; i++) stim[i] = vt[7].b;
    run_poly(2, 1'b1, 1'b0, -1, lat);
    check_poly(2, 1'b1, 1'b0, vt[7].e, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cbd_stream.md
CBD_STREAM -- requirements
Module: cbd_stream

Interface
REQ-001 Parameter P_IW, default 64: input word width in bits; SHALL be a multiple of 8 and divide both 1024 and 1536.
REQ-002 Parameter P_NC, default 8: coefficients per output beat; SHALL be a power of 2 in the range 1..32.
REQ-003 Ports:
  i_clk  in  1  clock
  i_rstn  in  1  reset, asynchronous, active-low
  i_start  in  1  one-cycle pulse; captures i_eta and i_mode
  i_eta  in  2  noise parameter; 2 or 3 valid
  i_mode  in  1  0 = signed two's-complement output, 1 = mod-q output (q = 3329)
  i_ibytes  in  P_IW  input bytes; first byte in MSBs
  i_ibytes_valid  in  1  input word valid
  o_ibytes_ready  out  1  input word accepted when valid & ready
  o_coeffs  out  12*P_NC  coefficients; coefficient 0 in bits [11:0]
  o_coeffs_valid  out  1  output beat valid
  i_coeffs_ready  in  1  output beat accepted when valid & ready
  o_busy  out  1  high from accepted start until done
  o_done  out  1  one-cycle pulse after the last beat is accepted
  o_err  out  1  one-cycle pulse on start with an invalid eta

Function
REQ-004 The block SHALL process one polynomial per start: 256 coefficients from 64*eta bytes, i.e. 512*eta/P_IW input words and 256/P_NC output beats.
REQ-005 Bit order SHALL be stream bit k = bit (k mod 8) of byte floor(k/8).
- Coefficient i SHALL be the sum over j<eta of bit(2*eta*i+j), minus the sum over j<eta of bit(2*eta*i+eta+j).
REQ-006 In mode 0, each coefficient SHALL be sign-extended to 12 bits; in mode 1, negative values SHALL be output as value+3329 (range 0..3328).
REQ-007 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on i_start with i_eta in {2,3}.
- RUN->DONE when the final beat handshakes.
- DONE->IDLE after 1 cycle; o_done SHALL be high only in DONE.
REQ-008 A start with i_eta not in {2,3} SHALL pulse o_err the next cycle; the FSM SHALL stay in IDLE.
REQ-009 i_start SHALL be ignored while in RUN or DONE; eta and mode SHALL be held constant for the whole polynomial.
REQ-010 The internal bit buffer SHALL hold P_IW + 6*P_NC bits and track its fill count.
REQ-011 o_ibytes_ready SHALL be high only when all of the following hold:
- state is RUN;
- input words remaining > 0;
- fill + P_IW <= capacity.
- o_ibytes_ready SHALL be low in IDLE and DONE.
REQ-012 A beat SHALL be formed when fill >= 2*eta*P_NC and the output register is empty or is being accepted in the same cycle.
- o_coeffs_valid SHALL assert in the cycle after that condition holds.
REQ-013 Input accept and beat formation in the same cycle SHALL be legal; fill SHALL update by +P_IW - 2*eta*P_NC in one step.
REQ-014 While o_coeffs_valid & !i_coeffs_ready, o_coeffs SHALL stay stable.
- No beat SHALL be dropped or duplicated.
- The input SHALL stall by deasserting ready when the buffer is full.
REQ-015 With i_ibytes_valid and i_coeffs_ready held high, throughput SHALL be one beat per cycle whenever bits are available.
- o_done SHALL occur no later than max(words, beats) + 4 cycles after start.
REQ-016 Words arriving when o_ibytes_ready is low SHALL be ignored.
- No input SHALL be consumed beyond the per-polynomial word count.

Reset
REQ-017 On i_rstn low, all of the following SHALL be 0 immediately: o_coeffs, o_coeffs_valid, o_ibytes_ready, o_busy, o_done, o_err.
- The FSM SHALL return to IDLE.
- Fill and all counters SHALL clear.
REQ-018 Reset mid-RUN SHALL discard the partial polynomial; the next valid start SHALL behave as if from power-up.

Verification
REQ-019 Zeros: P_NC=8, eta=2, mode 0, 16 all-zero words, ready=1 -> 32 beats, all coefficients 0, one o_done pulse after beat 32.
REQ-020 Sign/mode: eta=2, every byte 0x0C.
- Mode 0 -> every coefficient pair is [0xFFE, 0x000].
- Mode 1 -> every pair is [0xCFF, 0x000].
- With bytes 0x03, pairs are [0x002, 0x000].
REQ-021 Golden: 50 vectors from vec/cbd (mixed eta 2/3), mode 0 -> bits [2:0] of each coefficient match o_coeffs.vec for all 256 coefficients, zero mismatches.
REQ-022 Backpressure: eta=3, i_coeffs_ready low for 10 cycles, then randomly toggled.
- o_coeffs stays stable while stalled.
- o_ibytes_ready drops when the buffer is full.
- 24 words in, 32 beats out, data matches the golden vector.
REQ-023 Errors/boundaries:
- Start with eta=1 -> o_err pulse, o_busy stays 0.
- Start while busy -> ignored.
- Reset after 5 words -> all outputs 0; the following start completes correctly.
